pipe_out_block_fifo: RTL and testbench

//  Block-throttled source buffer feeding an okBTPipeOut endpoint on ti_clk.

---
 rtl/pipe_out_block_fifo.sv | 140 ++++++++++++++
 tb/tb_pipe_out_block_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pipe_out_block_fifo.sv
// Block-throttled word FIFO feeding an okBTPipeOut endpoint; ready only while a full block is buffered.
// Optional statistics counters (drop_count, block_count) are built when PIPE_OUT_FIFO_STATS_EN is defined.
module pipe_out_block_fifo #(
  parameter int DEPTH_LOG2  = 10,
  parameter int BLOCK_WORDS = 256,
  parameter int WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  wr_full,
  input  logic                  pipe_out_blockstrobe,
  input  logic                  pipe_out_read,
  output logic [WIDTH-1:0]      pipe_out_data,
  output logic                  pipe_out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  underflow
`ifdef PIPE_OUT_FIFO_STATS_EN
  ,
  output logic [15:0]           drop_count,
  output logic [15:0]           block_count
`endif
);

  localparam int                DEPTH   = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] BLK_C   = (DEPTH_LOG2+1)'(BLOCK_WORDS);
  localparam logic [DEPTH_LOG2:0] ONE_C   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_INC = DEPTH_LOG2'(1);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BURST} state_t;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count, burst_cnt;
  state_t                state, state_nxt;
  logic                  rd_acc, wr_acc, drop, rd_empty, burst_done;

  // A write at full only fits if a read frees a slot in the same cycle.
  assign rd_acc     = pipe_out_read && (count != '0);
  assign wr_acc     = wr_en && ((count < DEPTH_C) || rd_acc);
  assign drop       = wr_en && !wr_acc;
  assign rd_empty   = pipe_out_read && (count == '0);
  assign burst_done = (state == S_BURST) && rd_acc && (burst_cnt == ONE_C);

  assign wr_full = (count == DEPTH_C);
  assign level   = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PTR_INC;
      if (rd_acc) rptr <= rptr + PTR_INC;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc && !clear) mem[wptr] <= wr_data;
  end

  // Output word holds across empty reads and clear; only reset zeroes it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               pipe_out_data <= '0;
    else if (rd_acc && !clear)  pipe_out_data <= mem[rptr];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clear) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (drop)     overflow  <= 1'b1;
      if (rd_empty) underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      burst_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (clear)
        burst_cnt <= '0;
      else if (state == S_ARMED && pipe_out_blockstrobe)
        burst_cnt <= BLK_C;
      else if (state == S_BURST && rd_acc)
        burst_cnt <= burst_cnt - ONE_C;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (count >= BLK_C)        state_nxt = S_ARMED;
      S_ARMED: if (pipe_out_blockstrobe)  state_nxt = S_BURST;
      S_BURST: if (burst_done)            state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
    if (clear) state_nxt = S_IDLE;
  end

  always_comb begin
    pipe_out_ready = (state == S_ARMED);
  end

`ifdef PIPE_OUT_FIFO_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count  <= '0;
      block_count <= '0;
    end else if (clear) begin
      drop_count  <= '0;
      block_count <= '0;
    end else begin
      if (drop && drop_count != 16'hFFFF)        drop_count  <= drop_count + 16'd1;
      if (burst_done && block_count != 16'hFFFF) block_count <= block_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_out_block_fifo.sv
// Directed bench for pipe_out_block_fifo: a per-cycle vector table plus block/burst/reset sequences.
module tb_pipe_out_block_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear, wr_en, pipe_out_blockstrobe, pipe_out_read;
  logic [15:0] wr_data, pipe_out_data;
  logic        wr_full, pipe_out_ready, overflow, underflow;
  logic [10:0] level;
`ifdef PIPE_OUT_FIFO_STATS_EN
  logic [15:0] drop_count, block_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_out_block_fifo dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
    .pipe_out_blockstrobe(pipe_out_blockstrobe), .pipe_out_read(pipe_out_read),
    .pipe_out_data(pipe_out_data), .pipe_out_ready(pipe_out_ready),
    .level(level), .overflow(overflow), .underflow(underflow)
`ifdef PIPE_OUT_FIFO_STATS_EN
    , .drop_count(drop_count), .block_count(block_count)
`endif
  );

  typedef struct {
    logic        w;
    logic [15:0] d;
    logic        r;
    logic        s;
    logic        c;
    logic [10:0] lvl;
    logic        rdy;
    logic [15:0] dat;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cyc(input logic w, input logic [15:0] d, input logic r, input logic s, input logic c);
    wr_en = w; wr_data = d; pipe_out_read = r; pipe_out_blockstrobe = s; clear = c;
    @(posedge clk);
    #1;
    wr_en = 1'b0; pipe_out_read = 1'b0; pipe_out_blockstrobe = 1'b0; clear = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{1'b1, 16'h00A1, 1'b0, 1'b0, 1'b0, 11'd1, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 16'h00B2, 1'b0, 1'b0, 1'b0, 11'd2, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd1, 1'b0, 16'h00A1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 16'h00C3, 1'b1, 1'b0, 1'b0, 11'd1, 1'b0, 16'h00B2, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 16'h00C3, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 16'h00C3, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 16'h00D4, 1'b1, 1'b0, 1'b0, 11'd1, 1'b0, 16'h00C3, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 16'h00E5, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 16'h00C3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 16'h00C3, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 11'd0, 1'b0, 16'h00C3, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 16'h0011, 1'b0, 1'b0, 1'b0, 11'd1, 1'b0, 16'h00C3, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 16'h0011, 1'b0, 1'b0};

    reset_n = 1'b0; clear = 1'b0; wr_en = 1'b0; wr_data = '0;
    pipe_out_read = 1'b0; pipe_out_blockstrobe = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ready", 32'(pipe_out_ready), 32'd0);
    chk("rst_data",  32'(pipe_out_data), 32'd0);
    chk("rst_full",  32'(wr_full), 32'd0);
    chk("rst_flags", {30'd0, overflow, underflow}, 32'd0);
    reset_n = 1'b1;

    // Per-cycle basics: push/pop ordering, empty reads, no bypass, clear priority.
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].s, tbl[i].c);
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("vec%0d_ready", i), 32'(pipe_out_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_data", i),  32'(pipe_out_data), 32'(tbl[i].dat));
      chk($sformatf("vec%0d_ovf", i),   32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("vec%0d_unf", i),   32'(underflow), 32'(tbl[i].unf));
    end

    // Block threshold: 255 words keep ready low; the 256th arms one cycle later.
    for (int i = 0; i < 255; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    chk("t1_level255", 32'(level), 32'd255);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_ready255", 32'(pipe_out_ready), 32'd0);
    cyc(1'b1, 16'd255, 1'b0, 1'b0, 1'b0);
    chk("t1_level256", 32'(level), 32'd256);
    chk("t1_ready_lag", 32'(pipe_out_ready), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_ready", 32'(pipe_out_ready), 32'd1);

    // Full burst of 256 reads out of a 512-word backlog.
    for (int i = 256; i < 512; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    chk("t2_level512", 32'(level), 32'd512);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_ready_burst", 32'(pipe_out_ready), 32'd0);
    for (int i = 0; i < 256; i++) begin
      cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t2_data%0d", i), 32'(pipe_out_data), 32'(i));
    end
    chk("t2_ready_end", 32'(pipe_out_ready), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t2_rearm", 32'(pipe_out_ready), 32'd1);
    chk("t2_level256", 32'(level), 32'd256);
`ifdef PIPE_OUT_FIFO_STATS_EN
    chk("t2_block_count", 32'(block_count), 32'd1);
`endif

    // Full FIFO: simultaneous write+read is accepted, then plain writes drop.
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1024; i++) cyc(1'b1, 16'(i + 16'h1000), 1'b0, 1'b0, 1'b0);
    chk("t3_full", 32'(wr_full), 32'd1);
    chk("t3_level", 32'(level), 32'd1024);
    cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    chk("t4_level", 32'(level), 32'd1024);
    chk("t4_ovf", 32'(overflow), 32'd0);
    chk("t4_data", 32'(pipe_out_data), 32'h1000);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_level_hold", 32'(level), 32'd1024);
    chk("t3_full_hold", 32'(wr_full), 32'd1);
`ifdef PIPE_OUT_FIFO_STATS_EN
    chk("t3_drop_count", 32'(drop_count), 32'd3);
`endif

    // Clear, ignored strobe in IDLE, then async reset in the middle of a burst.
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("t5_clear_level", 32'(level), 32'd0);
    chk("t5_clear_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("t5_clear_ready", 32'(pipe_out_ready), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) cyc(1'b1, 16'(i + 16'h0100), 1'b0, 1'b0, 1'b0);
    chk("t6_idle_strobe", 32'(pipe_out_ready), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_ready", 32'(pipe_out_ready), 32'd1);
    cyc(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 100; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    chk("t6_data99", 32'(pipe_out_data), 32'h0163);
    chk("t6_level156", 32'(level), 32'd156);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(pipe_out_ready), 32'd0);
    chk("t6_rst_level", 32'(level), 32'd0);
    chk("t6_rst_data",  32'(pipe_out_data), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 256; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    chk("t6_refill_ready", 32'(pipe_out_ready), 32'd1);
    chk("t6_refill_level", 32'(level), 32'd256);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
